// File: rtl/chan_mux_seq_if.sv
// Stream interface of the channel multiplexer: parallel channel words, the
// host select request, the scan launch and the registered output stream.
interface chan_mux_seq_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 9,
  parameter int SEL_W = 5
);
  logic [N_CH*WIDTH-1:0] data_in;
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic                  sel_valid;
  logic                  sel_ready;
  logic                  start;
  logic [WIDTH-1:0]      data_out;
  logic [SEL_W-1:0]      out_ch;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  done;
  logic                  sel_err;

  // Host / upstream side.
  modport master (
    output data_in, mode, sel, sel_valid, start, out_ready,
    input  sel_ready, data_out, out_ch, out_valid, busy, done, sel_err
  );

  // Multiplexer side.
  modport slave (
    input  data_in, mode, sel, sel_valid, start, out_ready,
    output sel_ready, data_out, out_ch, out_valid, busy, done, sel_err
  );
endinterface

// File: rtl/chan_mux_seq.sv
// Registered N_CH-to-1 channel multiplexer with valid/ready output. DIRECT
// mode serves one host-selected channel per request; SCAN mode streams all
// channels 0..N_CH-1 after a start pulse, optionally from a start snapshot.
module chan_mux_seq #(
  parameter int WIDTH    = 8,
  parameter int N_CH     = 9,
  parameter int SEL_W    = 5,
  parameter bit SNAPSHOT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  chan_mux_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_e;

  localparam logic [SEL_W:0]   N_CH_EXT = (SEL_W+1)'(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] snap_q [N_CH];
  logic [WIDTH-1:0] snap_d [N_CH];
  logic [WIDTH-1:0] live_w [N_CH];
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             sel_err_q, sel_err_d;
  logic             slot_free;
  logic             sel_ready_w;
  logic [WIDTH-1:0] sel_word;
  logic [WIDTH-1:0] scan_word;

  // Output register can take a new word when empty or being drained now.
  assign slot_free = !out_valid_q || bus.out_ready;

  // Unpack the flat channel bus and pick the DIRECT and SCAN words by compare,
  // so out-of-range select codes simply match nothing.
  always_comb begin
    sel_word  = '0;
    scan_word = '0;
    for (int k = 0; k < N_CH; k++) begin
      live_w[k] = bus.data_in[k*WIDTH +: WIDTH];
      if (bus.sel == SEL_W'(k)) sel_word = live_w[k];
      if (idx_q == SEL_W'(k))   scan_word = SNAPSHOT ? snap_q[k] : live_w[k];
    end
  end

  // Next-state, output-slot and handshake logic.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    state_d     = state_q;
    idx_d       = idx_q;
    snap_d      = snap_q;
    data_out_d  = data_out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    done_d      = 1'b0;
    sel_err_d   = 1'b0;
    sel_ready_w = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.mode) begin
          if (bus.start) begin
            state_d = SCAN;
            idx_d   = '0;
            if (SNAPSHOT) snap_d = live_w;
          end
        end else begin
          // Held low during reset so every output reads 0 while rst_n is low.
          sel_ready_w = slot_free && rst_n;
          if (bus.sel_valid && slot_free) begin
            if ({1'b0, bus.sel} < N_CH_EXT) begin
              data_out_d  = sel_word;
              out_ch_d    = bus.sel;
              out_valid_d = 1'b1;
            end else begin
              sel_err_d = 1'b1;
            end
          end
        end
      end
      SCAN: begin
        if (slot_free) begin
          data_out_d  = scan_word;
          out_ch_d    = idx_q;
          out_valid_d = 1'b1;
          if (idx_q == LAST_CH) state_d = DRAIN;
          else                  idx_d   = idx_q + 1'b1;
        end
      end
      DRAIN: begin
        // Only the last channel's word can still be in the slot here.
        if (out_valid_q && bus.out_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, index, snapshot and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      // NOTE: the snapshot array is small and must read as 0 after reset, so
      // it is reset like ordinary flops rather than left as an unreset memory.
      for (int k = 0; k < N_CH; k++) snap_q[k] <= '0;
      data_out_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples the values
      // computed before this edge regardless of statement order.
      state_q     <= state_d;
      idx_q       <= idx_d;
      snap_q      <= snap_d;
      data_out_q  <= data_out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign bus.sel_ready = sel_ready_w;
  assign bus.data_out  = data_out_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_chan_mux_seq.sv
// Directed bench for chan_mux_seq: a scoreboard queue receives every expected
// output word when stimulus is driven; a negedge monitor pops and compares on
// each accepted transfer.
module tb_chan_mux_seq;

  localparam int WIDTH = 8;
  localparam int N_CH  = 9;
  localparam int SEL_W = 5;

  typedef struct packed {
    logic [SEL_W-1:0] ch;
    logic [WIDTH-1:0] data;
  } word_t;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  int   done_base;
  word_t sb [$];

  chan_mux_seq_if #(.WIDTH(WIDTH), .N_CH(N_CH), .SEL_W(SEL_W)) bus ();

  chan_mux_seq #(.WIDTH(WIDTH), .N_CH(N_CH), .SEL_W(SEL_W), .SNAPSHOT(1'b1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int base);
    for (int k = 0; k < N_CH; k++) bus.data_in[k*WIDTH +: WIDTH] = WIDTH'(base + k);
  endtask

  task automatic push_scan(input int base);
    for (int k = 0; k < N_CH; k++) sb.push_back('{ch: SEL_W'(k), data: WIDTH'(base + k)});
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int n = 0;
    while (bus.done !== 1'b1 && n < max_cycles) begin
      step();
      n++;
    end
    check(tag, {31'b0, bus.done}, 32'd1);
  endtask

  // Scoreboard monitor: a transfer happens on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected: observed ch=%0d data=%0h, expected no word", bus.out_ch, bus.data_out);
      end
      if (sb.size() > 0) begin
        word_t w;
        w = sb.pop_front();
        check("sb_ch", {27'b0, bus.out_ch}, {27'b0, w.ch});
        check("sb_data", {24'b0, bus.data_out}, {24'b0, w.data});
      end
    end
    if (bus.done === 1'b1) done_cnt++;
  end

  initial begin
    rst_n         = 1'b0;
    bus.data_in   = '0;
    bus.mode      = 1'b0;
    bus.sel       = '0;
    bus.sel_valid = 1'b0;
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_busy",      {31'b0, bus.busy},      32'd0);
    check("rst_sel_ready", {31'b0, bus.sel_ready}, 32'd0);
    check("rst_data_out",  {24'b0, bus.data_out},  32'd0);
    rst_n = 1'b1;
    set_data(8'h10);
    step();
    check("idle_sel_ready", {31'b0, bus.sel_ready}, 32'd1);

    // DIRECT: channel 3 then channel 8 back to back.
    bus.sel = 5'd3; bus.sel_valid = 1'b1;
    sb.push_back('{ch: 5'd3, data: 8'h13});
    check("dir_sel_ready", {31'b0, bus.sel_ready}, 32'd1);
    step();
    check("dir3_valid", {31'b0, bus.out_valid}, 32'd1);
    check("dir3_ch",    {27'b0, bus.out_ch},    32'd3);
    check("dir3_data",  {24'b0, bus.data_out},  32'h13);
    bus.sel = 5'd8;
    sb.push_back('{ch: 5'd8, data: 8'h18});
    step();
    bus.sel_valid = 1'b0;
    check("dir8_ch",   {27'b0, bus.out_ch},   32'd8);
    check("dir8_data", {24'b0, bus.data_out}, 32'h18);
    step();
    check("dir_idle_valid", {31'b0, bus.out_valid}, 32'd0);

    // DIRECT error: sel 9 and 31 consumed without a load.
    bus.sel = 5'd9; bus.sel_valid = 1'b1;
    step();
    bus.sel_valid = 1'b0;
    check("err9_pulse", {31'b0, bus.sel_err},   32'd1);
    check("err9_valid", {31'b0, bus.out_valid}, 32'd0);
    check("err9_data",  {24'b0, bus.data_out},  32'h18);
    step();
    check("err9_end",   {31'b0, bus.sel_err},   32'd0);
    bus.sel = 5'd31; bus.sel_valid = 1'b1;
    step();
    bus.sel_valid = 1'b0;
    check("err31_pulse", {31'b0, bus.sel_err},   32'd1);
    check("err31_valid", {31'b0, bus.out_valid}, 32'd0);
    check("err31_data",  {24'b0, bus.data_out},  32'h18);
    step();
    check("err31_end",   {31'b0, bus.sel_err},   32'd0);

    // SCAN at full throughput.
    done_base = done_cnt;
    bus.mode = 1'b1; bus.start = 1'b1;
    push_scan(8'h10);
    step();
    bus.start = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      step();
      check("scan_busy",  {31'b0, bus.busy},      32'd1);
      check("scan_valid", {31'b0, bus.out_valid}, 32'd1);
      check("scan_ch",    {27'b0, bus.out_ch},    32'(i));
    end
    step();
    check("scan_done", {31'b0, bus.done}, 32'd1);
    check("scan_idle", {31'b0, bus.busy}, 32'd0);
    step();
    check("scan_done_end", {31'b0, bus.done},    32'd0);
    check("scan_done_cnt", 32'(done_cnt - done_base), 32'd1);
    check("scan_sb_empty", 32'(sb.size()), 32'd0);

    // SCAN with backpressure at channel 2 and data changed after start.
    done_base = done_cnt;
    bus.start = 1'b1;
    push_scan(8'h10);
    step();
    bus.start = 1'b0;
    bus.data_in = '1;
    step();
    check("bp_ch0", {27'b0, bus.out_ch}, 32'd0);
    step();
    step();
    check("bp_ch2", {27'b0, bus.out_ch}, 32'd2);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_ch",    {27'b0, bus.out_ch},    32'd2);
      check("bp_hold_data",  {24'b0, bus.data_out},  32'h12);
      check("bp_hold_valid", {31'b0, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    wait_done("bp_done", 20);
    step();
    check("bp_done_cnt", 32'(done_cnt - done_base), 32'd1);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Collisions: start with sel_valid, then start again mid-scan.
    set_data(8'h10);
    done_base = done_cnt;
    bus.start = 1'b1; bus.sel = 5'd3; bus.sel_valid = 1'b1;
    check("col_sel_ready", {31'b0, bus.sel_ready}, 32'd0);
    push_scan(8'h10);
    step();
    bus.start = 1'b0; bus.sel_valid = 1'b0;
    step();
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done("col_done", 20);
    step();
    check("col_done_cnt", 32'(done_cnt - done_base), 32'd1);
    check("col_sb_empty", 32'(sb.size()), 32'd0);
    repeat (3) step();
    check("col_no_rescan_busy",  {31'b0, bus.busy},      32'd0);
    check("col_no_rescan_valid", {31'b0, bus.out_valid}, 32'd0);

    // Reset mid-scan at idx 4: immediate abort, no done pulse.
    done_base = done_cnt;
    bus.start = 1'b1;
    push_scan(8'h10);
    step();
    bus.start = 1'b0;
    repeat (4) step();
    check("mid_ch3", {27'b0, bus.out_ch}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data",  {24'b0, bus.data_out},  32'd0);
    check("mid_rst_ch",    {27'b0, bus.out_ch},    32'd0);
    check("mid_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("mid_rst_busy",  {31'b0, bus.busy},      32'd0);
    check("mid_rst_done",  {31'b0, bus.done},      32'd0);
    check("mid_rst_err",   {31'b0, bus.sel_err},   32'd0);
    check("mid_rst_ready", {31'b0, bus.sel_ready}, 32'd0);
    sb.delete();
    step();
    rst_n = 1'b1;
    bus.mode = 1'b0;
    repeat (3) step();
    check("post_rst_busy",  {31'b0, bus.busy},      32'd0);
    check("post_rst_valid", {31'b0, bus.out_valid}, 32'd0);
    check("post_rst_done",  32'(done_cnt - done_base), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
